// File: rtl/ifid_pipe_stage_pkg.sv
// Shared defaults, empty-stage instruction and skid-buffer state encoding for the IF/ID pipeline stage.
package ifid_pipe_stage_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int PC_W_DEF    = 16;
    localparam int CTRL_W_DEF  = 2;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ifid_beat_reg.sv
// One IF/ID beat holding register: loads on i_en, synchronous clear on i_clr (clear wins).
// Output follows the edge after load; no handshake of its own.
module ifid_beat_reg
    import ifid_pipe_stage_pkg::*;
#(
    parameter int W = INSTR_W_DEF + PC_W_DEF + CTRL_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ifid_pipe_stage.sv
// IF/ID pipeline register; IFID_SKID_EN selects a 2-entry skid buffer (registered in_ready) over a single register.
// One-edge latency, flush empties the stage and beats the same-cycle accept; in_valid without in_ready is held upstream.
module ifid_pipe_stage
    import ifid_pipe_stage_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 CTRL_W    = CTRL_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occupancy
);

    localparam int BEAT_W = INSTR_W + PC_W + CTRL_W;

    logic [BEAT_W-1:0] w_in_beat;
    logic [BEAT_W-1:0] w_head_d;
    logic [BEAT_W-1:0] w_head_q;
    logic              w_head_en;
    logic              w_acc;
    logic              w_rel;

    assign w_in_beat = {in_instr, in_pc, in_ctrl};
    assign w_acc     = in_valid && in_ready;
    assign w_rel     = out_valid && out_ready;

`ifdef IFID_SKID_EN
    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic              r_in_rdy;
    logic              w_tail_en;
    logic [BEAT_W-1:0] w_tail_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= SKID_EMPTY;
            r_in_rdy <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (w_state_nxt != SKID_TWO);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_en   = 1'b0;
        w_tail_en   = 1'b0;
        if (!flush) begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_acc) begin
                        w_head_en   = 1'b1;
                        w_state_nxt = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (w_acc && w_rel) begin
                        w_head_en = 1'b1;
                    end else if (w_acc) begin
                        w_tail_en   = 1'b1;
                        w_state_nxt = SKID_TWO;
                    end else if (w_rel) begin
                        w_state_nxt = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only the tail can move forward.
                    if (w_rel) begin
                        w_head_en   = 1'b1;
                        w_state_nxt = SKID_ONE;
                    end
                end
                default: w_state_nxt = SKID_EMPTY;
            endcase
        end else begin
            w_state_nxt = SKID_EMPTY;
        end
    end

    ifid_beat_reg #(.W(BEAT_W)) u_tail (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_tail_en),
        .i_clr (flush),
        .i_d   (w_in_beat),
        .o_q   (w_tail_q)
    );

    assign w_head_d  = (r_state == SKID_TWO) ? w_tail_q : w_in_beat;
    assign in_ready  = r_in_rdy;
    assign out_valid = (r_state != SKID_EMPTY);
    assign occupancy = 2'(r_state);
`else
    logic r_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= 1'b0;
        end else if (flush) begin
            r_vld <= 1'b0;
        end else if (w_acc) begin
            r_vld <= 1'b1;
        end else if (w_rel) begin
            r_vld <= 1'b0;
        end
    end

    assign w_head_en = w_acc && !flush;
    assign w_head_d  = w_in_beat;
    assign in_ready  = !r_vld || out_ready;
    assign out_valid = r_vld;
    assign occupancy = {1'b0, r_vld};
`endif

    ifid_beat_reg #(.W(BEAT_W)) u_head (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_head_en),
        .i_clr (flush),
        .i_d   (w_head_d),
        .o_q   (w_head_q)
    );

    assign out_instr = out_valid ? w_head_q[BEAT_W-1 -: INSTR_W] : NOP_INSTR;
    assign out_pc    = out_valid ? w_head_q[CTRL_W +: PC_W]      : '0;
    assign out_ctrl  = out_valid ? w_head_q[CTRL_W-1:0]          : '0;

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Scoreboard bench for ifid_pipe_stage; follows the build's IFID_SKID_EN setting.
module tb_ifid_pipe_stage;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [1:0]  ctrl;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [15:0] in_pc = '0;
    logic [1:0]  in_ctrl = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [1:0]  out_ctrl;
    logic [1:0]  occupancy;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    ifid_pipe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    // Sideband is a fixed function of the instruction so every field is checked.
    function automatic beat_t mk(input logic [15:0] ins);
        beat_t b;
        b.instr = ins;
        b.pc    = ins ^ 16'h5A5A;
        b.ctrl  = ins[1:0] ^ 2'b11;
        return b;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] ins);
        beat_t b;
        b        = mk(ins);
        in_valid = v;
        in_instr = b.instr;
        in_pc    = b.pc;
        in_ctrl  = b.ctrl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] ins);
        exp_q.push_back(mk(ins));
    endtask

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_release actual=%h expected=none t=%0t", out_instr, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rel_instr", out_instr, e.instr);
                    chk("rel_pc", out_pc, e.pc);
                    chk("rel_ctrl", 16'(out_ctrl), 16'(e.ctrl));
                end
            end else if (rst && !out_valid) begin
                chk("idle_instr", out_instr, 16'h0000);
                chk("idle_pc", out_pc, 16'h0000);
                chk("idle_ctrl", 16'(out_ctrl), 16'h0000);
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset holds the stage empty despite an offered beat.
        drive(1'b1, 16'h1234);
        #12;
        chk("rst_out_valid", 16'(out_valid), 16'h0000);
        chk("rst_out_instr", out_instr, 16'h0000);
        chk("rst_out_pc", out_pc, 16'h0000);
        chk("rst_occupancy", 16'(occupancy), 16'h0000);
        chk("rst_in_ready", 16'(in_ready), 16'h0001);
        drive(1'b0, 16'h0000);
        #1 rst = 1'b1;
        step();
        chk("post_rst_occupancy", 16'(occupancy), 16'h0000);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(16'hA001 + 16'(i));
            drive(1'b1, 16'hA001 + 16'(i));
            step();
            chk("stream_occupancy", 16'(occupancy), 16'h0001);
        end
        drive(1'b0, 16'h0000);
        step();
        chk("stream_drained_occ", 16'(occupancy), 16'h0000);

        // Downstream stall.
        out_ready = 1'b0;
`ifdef IFID_SKID_EN
        drive(1'b1, 16'hB001);
        step();
        chk("stall_occ1", 16'(occupancy), 16'h0001);
        chk("stall_rdy1", 16'(in_ready), 16'h0001);
        drive(1'b1, 16'hB002);
        step();
        chk("stall_occ2", 16'(occupancy), 16'h0002);
        chk("stall_rdy2", 16'(in_ready), 16'h0000);
        chk("stall_head", out_instr, 16'hB001);
        drive(1'b1, 16'hB003);
        step();
        chk("stall_hold_occ", 16'(occupancy), 16'h0002);
        chk("stall_hold_rdy", 16'(in_ready), 16'h0000);
        chk("stall_hold_head", out_instr, 16'hB001);
        push(16'hB001);
        push(16'hB002);
        push(16'hB003);
        out_ready = 1'b1;
        step();
        step();
        drive(1'b0, 16'h0000);
        step();
        chk("stall_drain_occ", 16'(occupancy), 16'h0000);
`else
        drive(1'b1, 16'hD001);
        step();
        chk("ns_full_rdy", 16'(in_ready), 16'h0000);
        chk("ns_full_occ", 16'(occupancy), 16'h0001);
        drive(1'b1, 16'hD002);
        step();
        chk("ns_hold_occ", 16'(occupancy), 16'h0001);
        chk("ns_hold_head", out_instr, 16'hD001);
        push(16'hD001);
        push(16'hD002);
        push(16'hD003);
        out_ready = 1'b1;
        #1;
        chk("ns_comb_rdy", 16'(in_ready), 16'h0001);
        step();
        chk("ns_swap_head", out_instr, 16'hD002);
        drive(1'b1, 16'hD003);
        step();
        drive(1'b0, 16'h0000);
        step();
        chk("ns_drain_occ", 16'(occupancy), 16'h0000);
`endif

        // Flush with held beats and a colliding offer.
        out_ready = 1'b0;
        drive(1'b1, 16'hE001);
        step();
`ifdef IFID_SKID_EN
        drive(1'b1, 16'hE002);
        step();
        chk("flush_pre_occ", 16'(occupancy), 16'h0002);
`else
        chk("flush_pre_occ", 16'(occupancy), 16'h0001);
`endif
        drive(1'b1, 16'hC0DE);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0000);
        chk("flush_occ", 16'(occupancy), 16'h0000);
        chk("flush_out_valid", 16'(out_valid), 16'h0000);
        chk("flush_in_ready", 16'(in_ready), 16'h0001);
        out_ready = 1'b1;
        step();
        step();

        // Flush against an accept into an empty stage.
        drive(1'b1, 16'hC0DE);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0000);
        chk("flush_empty_valid", 16'(out_valid), 16'h0000);
        chk("flush_empty_occ", 16'(occupancy), 16'h0000);
        step();

        // Asynchronous reset while stalled.
        out_ready = 1'b0;
        drive(1'b1, 16'hF001);
        step();
`ifdef IFID_SKID_EN
        drive(1'b1, 16'hF002);
        step();
        chk("arst_pre_occ", 16'(occupancy), 16'h0002);
`else
        chk("arst_pre_occ", 16'(occupancy), 16'h0001);
`endif
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 16'(out_valid), 16'h0000);
        chk("arst_occupancy", 16'(occupancy), 16'h0000);
        chk("arst_out_instr", out_instr, 16'h0000);
        chk("arst_in_ready", 16'(in_ready), 16'h0001);
        drive(1'b0, 16'h0000);
        @(negedge clk);
        #1 rst = 1'b1;
        step();

        // Recovery beat after reset.
        out_ready = 1'b1;
        push(16'h6001);
        drive(1'b1, 16'h6001);
        step();
        chk("recover_head", out_instr, 16'h6001);
        drive(1'b0, 16'h0000);
        step();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step();
        end
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_stage.md
IFID_PIPE_STAGE -- requirements
Module: ifid_pipe_stage

Interface
REQ-001 Parameter INSTR_W, default 16: instruction width in bits.
REQ-002 Parameter PC_W, default 16: program-counter width in bits.
REQ-003 Parameter CTRL_W, default 2: sideband control width in bits.
REQ-004 Parameter NOP_INSTR, default 0: instruction value driven when the stage is empty.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  fetch side presents a beat.
REQ-008 in_ready  output  1  stage accepts a beat this cycle.
REQ-009 in_instr  input  INSTR_W  fetched instruction.
REQ-010 in_pc  input  PC_W  PC of fetched instruction.
REQ-011 in_ctrl  input  CTRL_W  fetch control sideband.
REQ-012 flush  input  1  discard all held and incoming beats (branch taken).
REQ-013 out_valid  output  1  decode side has a beat.
REQ-014 out_ready  input  1  decode accepts the beat (low = hazard stall).
REQ-015 out_instr / out_pc / out_ctrl  output  INSTR_W / PC_W / CTRL_W  head beat.
REQ-016 occupancy  output  2  number of beats held (0..2).

Function
REQ-017 Accept occurs when in_valid && in_ready; release occurs when out_valid && out_ready.
REQ-018 Beats SHALL leave in arrival order; no beat SHALL be duplicated or dropped except by flush.
REQ-019 Latency: a beat accepted at edge k SHALL be visible on the outputs after edge k (registered; no combinational in-to-out data path).
REQ-020 While out_valid=0: out_instr=NOP_INSTR, out_pc=0, out_ctrl=0.
REQ-021 Data outputs SHALL stay stable while out_valid && !out_ready.
REQ-022 Flush at edge k SHALL empty the stage: occupancy=0, out_valid=0 after k; a beat offered in the same cycle SHALL be discarded (flush wins over accept).
REQ-023 Simultaneous accept and release at the same occupancy SHALL keep occupancy unchanged and advance data.
REQ-024 in_valid with in_ready=0 SHALL not alter state; the upstream holds the beat.

Reset
REQ-025 While rst=0: occupancy=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_ctrl=0, in_ready=1 in skid mode.
REQ-026 Reset asserted mid-transfer SHALL discard every held beat immediately, without a clock.
REQ-027 The first accept after reset release SHALL occur no earlier than the first rising edge with rst=1.

Configuration
REQ-028 Macro IFID_SKID_EN selects the buffering mode.
REQ-029 With IFID_SKID_EN: a 2-entry skid buffer with states EMPTY, ONE, TWO; in_ready SHALL be a registered signal, high in EMPTY/ONE, low in TWO; EMPTY->ONE on accept; ONE->TWO on accept without release; TWO->ONE on release; ONE->EMPTY on release without accept; any state->EMPTY on flush.
REQ-030 Without IFID_SKID_EN: a single register; in_ready = !out_valid || out_ready (combinational from out_ready); occupancy never exceeds 1.

Structure
REQ-031 A shared package SHALL hold the default widths, the NOP_INSTR constant, and the skid state encoding typedef.
REQ-032 One sub-module ifid_beat_reg (an enable/clear register of width INSTR_W+PC_W+CTRL_W) SHALL be instantiated per entry.

Verification
REQ-033 Reset: rst=0 with in_valid=1, in_instr=16'h1234 -> out_valid=0, out_instr=16'h0000, occupancy=0.
REQ-034 Streaming: out_ready=1, beats instr 16'hA001..A004 on consecutive cycles -> each appears one edge later in order, occupancy=1 throughout.
REQ-035 Stall (skid mode): out_ready=0, offer 16'hB001, 16'hB002, 16'hB003 -> first two accepted, in_ready=0 after second edge, occupancy=2, out_instr=16'hB001 held; raise out_ready -> B001, B002, B003 released in order.
REQ-036 Flush collision: occupancy=2, flush=1 with in_valid=1, in_instr=16'hC0DE -> after edge occupancy=0, out_valid=0, C0DE never appears.
REQ-037 Async reset mid-stall: occupancy=2, drop rst between edges -> out_valid=0 and occupancy=0 before the next edge.
REQ-038 Non-skid build: out_ready=0 with a full register -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally and one beat is exchanged per cycle.
